prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader: the write side of the instruction RAM interface that the processor fetch path reads.
- Accepts program bytes over a valid/ready stream and packs them big-endian into 32-bit instruction words.
- Writes each word into the instruction RAM at consecutive addresses, then asserts working so the processor starts fetching from address 0.
- Replaces hand-driven addr/wr/wdata/working stimulus at processor level.

Parameters:
- ADDR_W, 9, RAM address width; word_count and addr use this width.
- BASE_ADDR, 0, address of the first loaded word.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- word_count  input  ADDR_W  number of 32-bit words to load; sampled with start.
- byte_in  input  8  program byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- stop  input  1  in RUN, return to IDLE and drop working.
- addr  output  ADDR_W  RAM write address.
- wr  output  1  RAM write strobe, one cycle per word.
- wdata  output  32  RAM write data.
- working  output  1  processor run enable.
- busy  output  1  high in COLLECT, WRITE and CHECK.
- err  output  1  checksum failure flag (see Optional Feature).

Behaviour:
- Reset, asynchronous: state=IDLE; addr=BASE_ADDR; wr=0; wdata=0; working=0; byte_ready=0; busy=0; err=0; byte counter=0; remaining=0. Any write in progress is abandoned immediately; wr falls without waiting for a clock edge.
- All outputs are registered except byte_ready, which is decoded from state.
- A byte is accepted on a rising edge with byte_valid && byte_ready. byte_in must be held until accepted. byte_ready never depends combinationally on byte_valid.

State machine (the CHECK state exists only when CHECKSUM_EN is defined):
- IDLE:
  - start=1 and word_count≠0: latch remaining=word_count, set addr=BASE_ADDR, clear err, go to COLLECT.
  - start=1 and word_count=0: go directly to RUN (or to CHECK with CHECKSUM_EN).
- COLLECT:
  - byte_ready=1.
  - Each accepted byte shifts into a 32-bit assembly register. The first byte lands in bits 31:24, the fourth in bits 7:0 (matches the icode/ifun/rA/rB/valC field order).
  - On the 4th accepted byte, load wdata from the assembly register including that byte, then go to WRITE.
- WRITE:
  - Exactly one cycle: wr=1, byte_ready=0.
  - Next edge: wr=0, addr=addr+1 modulo 2^ADDR_W (wrap from all-ones to 0 is legal), remaining=remaining−1.
  - If remaining was 1, go to RUN (or CHECK); otherwise go back to COLLECT.
  - Minimum 5 cycles per word.
- RUN:
  - working=1, busy=0, addr held at its last value (the processor ignores addr when working).
  - stop=1: working=0 on the next edge, go to IDLE.
- Boundary rules:
  - start is ignored outside IDLE.
  - start and stop asserted together in RUN: stop wins, and start is not honoured in the IDLE cycle that follows.
  - wr and working are never high in the same cycle.
  - byte_valid in IDLE or RUN is ignored (not consumed).
- Width rules:
  - remaining is ADDR_W bits, so a single load is at most 2^ADDR_W−1 words.
  - BASE_ADDR+word_count past the top of the address space wraps and overwrites low addresses; this is not flagged.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of every accepted program byte is kept, cleared on start.
  - After the last WRITE, the block enters CHECK with byte_ready=1 and accepts one checksum byte.
  - If the checksum byte equals the running XOR, go to RUN.
  - Otherwise set err=1 and return to IDLE with working=0; err stays set until reset or the next accepted start.
- When undefined: no CHECK state, no checksum byte, err tied to 0.

Test Plan:
1. Reset, then start with word_count=5 and bytes 10 f0 00 10 / 20 01 00 00 / 21 23 00 00 / 22 45 00 00 / 23 67 00 00 (valid held high) -> single-cycle wr at addr 0..4 with wdata 10f00010, 20010000, 21230000, 22450000, 23670000; working=1 one cycle after the last wr; processor fetch then returns icode 1,2,2,2,2.
2. Same load with byte_valid toggling 1-0-1-0 -> identical writes and values, each write delayed by the stall cycles; no byte dropped or duplicated.
3. BASE_ADDR=510, word_count=3 -> writes land at 510, 511, 0.
4. Assert reset in the WRITE cycle of word 2 -> wr drops asynchronously, all outputs return to reset values, and no further writes occur until a new start.
5. In RUN, assert stop with start=1 in the same cycle -> working=0 next cycle, state IDLE, no new load begins; a later start with word_count=0 -> working=1 one cycle after start.
6. With PROG_LOADER_CHECKSUM_EN, load word 01020304: checksum 04 -> RUN; checksum 05 -> err=1, working stays 0, state IDLE.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words, writes them to instruction RAM, then raises working.
// Optional trailing XOR checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              stop,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic [31:0]       wdata,
  output logic              working,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_RUN
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_DONE = S_CHECK;
`else
  localparam state_t S_DONE = S_RUN;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              working_q, working_d;
  logic              busy_q, busy_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              skip_q, skip_d;
  logic              accept;
  logic              start_ok;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;
`endif

  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      S_COLLECT: byte_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK:   byte_ready = 1'b1;
`endif
      default:   byte_ready = 1'b0;
    endcase
  end

  assign accept   = byte_valid && byte_ready;
  // A stop+start collision in RUN suppresses start for the following IDLE cycle.
  assign start_ok = start && !skip_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = (word_count != '0) ? S_COLLECT : S_DONE;
      S_COLLECT: if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE:   state_d = (remaining_q == ADDR_W'(1)) ? S_DONE : S_COLLECT;
      S_RUN:     if (stop) state_d = S_IDLE;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK:   if (accept) state_d = (byte_in == csum_q) ? S_RUN : S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    byte_cnt_d  = byte_cnt_q;
    remaining_d = remaining_q;
    skip_d      = (state_q == S_RUN) && stop && start;
    wr_d        = (state_d == S_WRITE);
    working_d   = (state_d == S_RUN);
    busy_d      = (state_d == S_COLLECT) || (state_d == S_WRITE);
`ifdef PROG_LOADER_CHECKSUM_EN
    err_d       = err_q;
    csum_d      = csum_q;
    busy_d      = busy_d || (state_d == S_CHECK);
`endif
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          remaining_d = word_count;
          addr_d      = BASE_ADDR;
          byte_cnt_d  = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
          err_d       = 1'b0;
          csum_d      = 8'h00;
`endif
        end
      end
      S_COLLECT: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_in;
`endif
          if (byte_cnt_q == 2'd3) wdata_d = {asm_q, byte_in};
        end
      end
      S_WRITE: begin
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept && byte_in != csum_q) err_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q      <= BASE_ADDR;
      wr_q        <= 1'b0;
      wdata_q     <= 32'h0;
      working_q   <= 1'b0;
      busy_q      <= 1'b0;
      asm_q       <= 24'h0;
      byte_cnt_q  <= 2'd0;
      remaining_q <= '0;
      skip_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      err_q       <= 1'b0;
      csum_q      <= 8'h00;
`endif
    end else begin
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      working_q   <= working_d;
      busy_q      <= busy_d;
      asm_q       <= asm_d;
      byte_cnt_q  <= byte_cnt_d;
      remaining_q <= remaining_d;
      skip_q      <= skip_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      err_q       <= err_d;
      csum_q      <= csum_d;
`endif
    end
  end

  assign addr    = addr_q;
  assign wr      = wr_q;
  assign wdata   = wdata_q;
  assign working = working_q;
  assign busy    = busy_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (BASE_ADDR 0 and 510) share one byte stream.
module tb_prog_loader;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] word_count = '0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          stop = 1'b0;

  logic          byte_ready0, wr0, working0, busy0, err0;
  logic [AW-1:0] addr0;
  logic [31:0]   wdata0;
  logic          byte_ready1, wr1, working1, busy1, err1;
  logic [AW-1:0] addr1;
  logic [31:0]   wdata1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  logic [AW+31:0] q0[$];
  logic [AW+31:0] q1[$];
  logic [31:0] mem0 [0:(1<<AW)-1];
  logic [31:0] ld [0:4];
  logic [7:0]  csum;

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(9'd0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready0), .stop(stop),
    .addr(addr0), .wr(wr0), .wdata(wdata0), .working(working0), .busy(busy0), .err(err0));

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(9'd510)) dut1 (
    .clock(clock), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready1), .stop(stop),
    .addr(addr1), .wr(wr1), .wdata(wdata1), .working(working1), .busy(busy1), .err(err1));

  always #5 clock = ~clock;

  task automatic monitor();
    logic [AW+31:0] e;
    logic prev0;
    prev0 = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (wr0) begin
        vectors++;
        if (q0.size() == 0) begin
          miscompares++;
          $display("FAIL wr0_unexpected got addr=%0d data=%h, required no write", addr0, wdata0);
        end else begin
          e = q0.pop_front();
          if ({addr0, wdata0} !== e) begin
            miscompares++;
            $display("FAIL wr0_word got addr=%0d data=%h, required addr=%0d data=%h",
                     addr0, wdata0, e[AW+31:32], e[31:0]);
          end
        end
        vectors++;
        if (working0 !== 1'b0 || prev0 !== 1'b0) begin
          miscompares++;
          $display("FAIL wr0_strobe got working=%b prev_wr=%b, required 0 0", working0, prev0);
        end
        mem0[addr0] = wdata0;
        last_wr_cyc = cyc;
      end
      if (wr1) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL wr1_unexpected got addr=%0d data=%h, required no write", addr1, wdata1);
        end else begin
          e = q1.pop_front();
          if ({addr1, wdata1} !== e) begin
            miscompares++;
            $display("FAIL wr1_word got addr=%0d data=%h, required addr=%0d data=%h",
                     addr1, wdata1, e[AW+31:32], e[31:0]);
          end
        end
      end
      prev0 = wr0;
    end
  endtask

  task automatic wait_accept(input string name);
    int n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clock);
      rdy = byte_ready0;
      @(posedge clock);
      #1;
      n++;
    end
    vectors++;
    if (!rdy) begin
      miscompares++;
      $display("FAIL %s_accept got byte_ready=0 for %0d cycles, required 1", name, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    byte_in = b;
    byte_valid = 1'b1;
    wait_accept("byte");
    csum = csum ^ b;
    if (toggle) begin
      byte_valid = 1'b0;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] wc);
    start = 1'b1;
    word_count = wc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic do_load(input int n, input bit toggle, input bit bad);
    csum = 8'h00;
    for (int k = 0; k < n; k++) begin
      q0.push_back({AW'(k), ld[k]});
      q1.push_back({AW'(510 + k), ld[k]});
      for (int i = 0; i < 4; i++) send_byte(ld[k][31-8*i -: 8], toggle);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    byte_in = csum ^ (bad ? 8'h01 : 8'h00);
    byte_valid = 1'b1;
    wait_accept("checksum");
`else
    if (bad) $display("note: checksum corruption requested without checksum build");
`endif
    byte_valid = 1'b0;
  endtask

  task automatic wait_working(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (!working0 && n < 200);
    vectors++;
    if (working0 !== 1'b1 || working1 !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_run got working=%b/%b busy=%b, required 1/1 0", name, working0, working1, busy0);
    end
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending got %0d/%0d writes outstanding, required 0/0", name, q0.size(), q1.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    @(posedge clock);
    #1;
    stop = 1'b0;
    vectors++;
    if (working0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL stop got working=%b busy=%b, required 0 0", working0, busy0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({addr0, addr1, wr0, wr1, wdata0, wdata1, working0, working1, busy0, busy1, err0, err1, byte_ready0, byte_ready1}
        !== {9'd0, 9'd510, 2'b00, 64'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state got addr=%0d/%0d wr=%b wdata=%h working=%b busy=%b err=%b rdy=%b, required 0/510 all zero",
               addr0, addr1, wr0, wdata0, working0, busy0, err0, byte_ready0);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_load();
    logic [3:0] icode [0:4];
    icode[0] = 4'h1; icode[1] = 4'h2; icode[2] = 4'h2; icode[3] = 4'h2; icode[4] = 4'h2;
    ld[0] = 32'h10f00010; ld[1] = 32'h20010000; ld[2] = 32'h21230000;
    ld[3] = 32'h22450000; ld[4] = 32'h23670000;
    do_start(9'd5);
    vectors++;
    if (busy0 !== 1'b1 || byte_ready0 !== 1'b1 || working0 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_collect got busy=%b rdy=%b working=%b, required 1 1 0", busy0, byte_ready0, working0);
    end
    do_load(5, 1'b0, 1'b0);
    wait_working("load");
`ifndef PROG_LOADER_CHECKSUM_EN
    vectors++;
    if (cyc - last_wr_cyc > 3) begin
      miscompares++;
      $display("FAIL load_latency got working %0d cycles after last wr, required 1", cyc - last_wr_cyc - 1);
    end
`endif
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (mem0[k][31:28] !== icode[k]) begin
        miscompares++;
        $display("FAIL fetch_icode addr=%0d got %h, required %h", k, mem0[k][31:28], icode[k]);
      end
    end
  endtask

  task automatic test_stall();
    stop_run();
    do_start(9'd5);
    do_load(5, 1'b1, 1'b0);
    wait_working("stall");
  endtask

  task automatic test_base_wrap();
    stop_run();
    ld[0] = 32'hA1B2C3D4; ld[1] = 32'h5566_7788; ld[2] = 32'h0F1E2D3C;
    do_start(9'd3);
    do_load(3, 1'b0, 1'b0);
    wait_working("wrap");
  endtask

  task automatic test_stop_start();
    start = 1'b1;
    stop = 1'b1;
    word_count = 9'd5;
    @(posedge clock);
    #1;
    stop = 1'b0;
    vectors++;
    if (working0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_wins got working=%b busy=%b, required 0 0", working0, busy0);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    vectors++;
    if (busy0 !== 1'b0 || byte_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL start_suppressed got busy=%b rdy=%b, required 0 0", busy0, byte_ready0);
    end
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (busy0 !== 1'b0 || working0 !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold got busy=%b working=%b, required 0 0", busy0, working0);
    end
    do_start(9'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    vectors++;
    if (busy0 !== 1'b1 || byte_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_check got busy=%b rdy=%b, required 1 1", busy0, byte_ready0);
    end
    byte_in = 8'h00;
    byte_valid = 1'b1;
    wait_accept("zero_checksum");
    byte_valid = 1'b0;
`endif
    vectors++;
    if (working0 !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_load got working=%b busy=%b, required 1 0", working0, busy0);
    end
  endtask

  task automatic test_reset_in_write();
    stop_run();
    ld[0] = 32'h30F40005; ld[1] = 32'h40450008;
    do_start(9'd5);
    csum = 8'h00;
    q0.push_back({AW'(0), ld[0]});
    q1.push_back({AW'(510), ld[0]});
    for (int i = 0; i < 4; i++) send_byte(ld[0][31-8*i -: 8], 1'b0);
    for (int i = 0; i < 4; i++) send_byte(ld[1][31-8*i -: 8], 1'b0);
    vectors++;
    if (wr0 !== 1'b1 || addr0 !== 9'd1) begin
      miscompares++;
      $display("FAIL word2_write got wr=%b addr=%0d, required 1 1", wr0, addr0);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (wr0 !== 1'b0 || wr1 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_drop got wr=%b/%b, required 0/0", wr0, wr1);
    end
    @(posedge clock);
    #1;
    vectors++;
    if ({addr0, addr1, wr0, wdata0, working0, busy0, err0, byte_ready0} !== {9'd0, 9'd510, 37'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs got addr=%0d/%0d wr=%b wdata=%h working=%b busy=%b err=%b rdy=%b, required 0/510 zeros",
               addr0, addr1, wr0, wdata0, working0, busy0, err0, byte_ready0);
    end
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    byte_valid = 1'b0;
    vectors++;
    if (busy0 !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_idle got busy=%b pending=%0d/%0d, required 0 0/0", busy0, q0.size(), q1.size());
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    ld[0] = 32'h01020304;
    do_start(9'd1);
    do_load(1, 1'b0, 1'b0);
    wait_working("csum_good");
    stop_run();
    do_start(9'd1);
    do_load(1, 1'b0, 1'b1);
    vectors++;
    if (err0 !== 1'b1 || err1 !== 1'b1 || working0 !== 1'b0 || busy0 !== 1'b0 || byte_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_bad got err=%b/%b working=%b busy=%b rdy=%b, required 1/1 0 0 0",
               err0, err1, working0, busy0, byte_ready0);
    end
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (err0 !== 1'b1 || working0 !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_err_hold got err=%b working=%b, required 1 0", err0, working0);
    end
    do_start(9'd1);
    vectors++;
    if (err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_err_clear got err=%b, required 0", err0);
    end
    do_load(1, 1'b0, 1'b0);
    wait_working("csum_retry");
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_load();
    test_stall();
    test_base_wrap();
    test_stop_start();
    test_reset_in_write();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
